// File: rtl/div_multistep_pkg.sv
// Shared definitions for the execute-stage divider: funct3 encodings, FSM states, step limit.
package tinyriscv_pkg;

  localparam logic [2:0] INST_DIV  = 3'b100;
  localparam logic [2:0] INST_DIVU = 3'b101;
  localparam logic [2:0] INST_REM  = 3'b110;
  localparam logic [2:0] INST_REMU = 3'b111;

  localparam int DIV_MAX_BPC = 4;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_CALC,
    DIV_FIX,
    DIV_OUT
  } div_state_e;

endpackage

// File: rtl/div_multistep_if.sv
// Request/result handshake bundle for div_multistep; the divider uses the slave modport.
interface div_multistep_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [2:0]       op_i;
  logic [WIDTH-1:0] dividend_i;
  logic [WIDTH-1:0] divisor_i;
  logic [TAG_W-1:0] tag_i;
  logic             flush_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] result_o;
  logic [TAG_W-1:0] tag_o;

  modport master (
    output in_valid_i, op_i, dividend_i, divisor_i, tag_i, flush_i, out_ready_i,
    input  in_ready_o, out_valid_o, result_o, tag_o
  );

  modport slave (
    input  in_valid_i, op_i, dividend_i, divisor_i, tag_i, flush_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o, tag_o
  );
endinterface

// File: rtl/div_multistep_step.sv
// div_step: BITS_PER_CYCLE chained restoring-division steps, purely combinational.
module div_step
  import tinyriscv_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [WIDTH-1:0]          rem_i,
  input  logic [BITS_PER_CYCLE-1:0] dvd_bits_i,
  input  logic [WIDTH-1:0]          dvs_i,
  output logic [WIDTH-1:0]          rem_o,
  output logic [BITS_PER_CYCLE-1:0] quo_o
);

  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_rem;

  // Dividend bits are consumed MSB first; the remainder always stays below the divisor.
  always_comb begin
    w_rem   = rem_i;
    w_trial = '0;
    quo_o   = '0;
    for (int i = BITS_PER_CYCLE - 1; i >= 0; i--) begin
      w_trial = {w_rem, dvd_bits_i[i]};
      if (w_trial >= {1'b0, dvs_i}) begin
        w_trial  = w_trial - {1'b0, dvs_i};
        quo_o[i] = 1'b1;
      end
      w_rem = w_trial[WIDTH-1:0];
    end
    rem_o = w_rem;
  end

endmodule

// File: rtl/div_multistep.sv
// div_multistep: iterative DIV/DIVU/REM/REMU with BITS_PER_CYCLE quotient bits per cycle.
// Defining DIV_RESULT_CACHE_EN adds a last-result cache that short-circuits repeated operands.
module div_multistep
  import tinyriscv_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter int TAG_W          = 5
) (
  input logic           clk_i,
  input logic           rst_i,
  div_multistep_if.slave bus
);

  localparam int N     = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(N);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e       r_state, w_state_nxt;
  logic [TAG_W-1:0] r_tag;
  logic [WIDTH-1:0] r_dvd, r_dvs, r_rem, r_quo, r_result;
  logic [CNT_W-1:0] r_cnt;
  logic             r_is_rem, r_q_neg, r_r_neg, r_out_valid;

  logic w_in_ready, w_accept, w_calc_done;
  logic w_signed, w_is_rem, w_dvd_neg, w_dvs_neg, w_special, w_hit;
  logic [WIDTH-1:0] w_dvd_abs, w_dvs_abs, w_special_res, w_hit_res;
  logic [WIDTH-1:0] w_step_rem, w_fix_quo, w_fix_rem;
  logic [BITS_PER_CYCLE-1:0] w_step_quo;

  assign w_signed  = ~bus.op_i[0];
  assign w_is_rem  = bus.op_i[1];
  assign w_dvd_neg = w_signed & bus.dividend_i[WIDTH-1];
  assign w_dvs_neg = w_signed & bus.divisor_i[WIDTH-1];
  assign w_dvd_abs = w_dvd_neg ? -bus.dividend_i : bus.dividend_i;
  assign w_dvs_abs = w_dvs_neg ? -bus.divisor_i : bus.divisor_i;
  assign w_fix_quo = r_q_neg ? -r_quo : r_quo;
  assign w_fix_rem = r_r_neg ? -r_rem : r_rem;

  // Non-divide ops, divide-by-zero and signed overflow never enter CALC.
  always_comb begin
    w_special     = 1'b1;
    w_special_res = '0;
    if (!bus.op_i[2]) begin
      w_special_res = '0;
    end else if (bus.divisor_i == '0) begin
      w_special_res = w_is_rem ? bus.dividend_i : '1;
    end else if (w_signed && bus.dividend_i == MOST_NEG && bus.divisor_i == '1) begin
      w_special_res = w_is_rem ? '0 : bus.dividend_i;
    end else begin
      w_special = 1'b0;
    end
  end

`ifdef DIV_RESULT_CACHE_EN
  logic             r_c_valid, r_c_signed, r_op_signed;
  logic [WIDTH-1:0] r_c_dvd, r_c_dvs, r_c_quo, r_c_rem, r_op_dvd, r_op_dvs;

  assign w_hit     = r_c_valid & (r_c_dvd == bus.dividend_i) & (r_c_dvs == bus.divisor_i)
                   & (r_c_signed == w_signed);
  assign w_hit_res = w_is_rem ? r_c_rem : r_c_quo;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_c_valid   <= 1'b0;
      r_c_signed  <= 1'b0;
      r_op_signed <= 1'b0;
      r_c_dvd     <= '0;
      r_c_dvs     <= '0;
      r_c_quo     <= '0;
      r_c_rem     <= '0;
      r_op_dvd    <= '0;
      r_op_dvs    <= '0;
    end else if (bus.flush_i) begin
      r_c_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op_dvd    <= bus.dividend_i;
        r_op_dvs    <= bus.divisor_i;
        r_op_signed <= w_signed;
      end
      if (r_state == DIV_FIX) begin
        r_c_valid  <= 1'b1;
        r_c_dvd    <= r_op_dvd;
        r_c_dvs    <= r_op_dvs;
        r_c_signed <= r_op_signed;
        r_c_quo    <= w_fix_quo;
        r_c_rem    <= w_fix_rem;
      end
    end
  end
`else
  assign w_hit     = 1'b0;
  assign w_hit_res = '0;
`endif

  div_step #(
    .WIDTH         (WIDTH),
    .BITS_PER_CYCLE(BITS_PER_CYCLE)
  ) u_step (
    .rem_i     (r_rem),
    .dvd_bits_i(r_dvd[WIDTH-1 -: BITS_PER_CYCLE]),
    .dvs_i     (r_dvs),
    .rem_o     (w_step_rem),
    .quo_o     (w_step_quo)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= DIV_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.flush_i) begin
      w_state_nxt = DIV_IDLE;
    end else begin
      case (r_state)
        DIV_IDLE: if (w_accept) w_state_nxt = (w_special || w_hit) ? DIV_OUT : DIV_CALC;
        DIV_CALC: if (w_calc_done) w_state_nxt = DIV_FIX;
        DIV_FIX:  w_state_nxt = DIV_OUT;
        DIV_OUT:  if (bus.out_ready_i) w_state_nxt = DIV_IDLE;
        default:  w_state_nxt = DIV_IDLE;
      endcase
    end
  end

  always_comb begin
    w_in_ready  = (r_state == DIV_IDLE) && !rst_i;
    w_accept    = bus.in_valid_i && w_in_ready && !bus.flush_i;
    w_calc_done = (r_cnt == CNT_W'(N - 1));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tag       <= '0;
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_result    <= '0;
      r_cnt       <= '0;
      r_is_rem    <= 1'b0;
      r_q_neg     <= 1'b0;
      r_r_neg     <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (bus.flush_i) begin
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        DIV_IDLE: if (w_accept) begin
          r_tag    <= bus.tag_i;
          r_is_rem <= w_is_rem;
          r_dvd    <= w_dvd_abs;
          r_dvs    <= w_dvs_abs;
          r_q_neg  <= w_dvd_neg ^ w_dvs_neg;
          r_r_neg  <= w_dvd_neg;
          r_cnt    <= '0;
          r_rem    <= '0;
          r_quo    <= '0;
          if (w_special) begin
            r_result    <= w_special_res;
            r_out_valid <= 1'b1;
          end else if (w_hit) begin
            r_result    <= w_hit_res;
            r_out_valid <= 1'b1;
          end
        end
        DIV_CALC: begin
          r_dvd <= r_dvd << BITS_PER_CYCLE;
          r_rem <= w_step_rem;
          r_quo <= {r_quo[WIDTH-BITS_PER_CYCLE-1:0], w_step_quo};
          r_cnt <= r_cnt + CNT_W'(1);
        end
        DIV_FIX: begin
          r_result    <= r_is_rem ? w_fix_rem : w_fix_quo;
          r_out_valid <= 1'b1;
        end
        DIV_OUT: if (bus.out_ready_i) r_out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.in_ready_o  = w_in_ready;
  assign bus.out_valid_o = r_out_valid;
  assign bus.result_o    = r_result;
  assign bus.tag_o       = r_tag;

endmodule

// File: doc/div_multistep.md
# div_multistep

Parametrised iterative integer divider for the RV32M/RV64M execute stage. Computes DIV/DIVU/REM/REMU with a configurable number of restoring-division bits per cycle. Uses a valid/ready handshake on both the request and result sides, and carries a destination tag through the operation. Sits beside the ALU and multiplier; the pipeline stalls on `in_ready_o`/`out_valid_o`.

## Interface
- `WIDTH`, 32: operand and result width; must be 32 or 64.
- `BITS_PER_CYCLE`, 1: quotient bits resolved per CALC cycle; must be 1, 2 or 4 and must divide `WIDTH`.
- `TAG_W`, 5: width of the pass-through tag (rd index).
- `clk_i`  in  1: clock; all state changes on the rising edge.
- `rst_i`  in  1: reset, synchronous, active-high.
- `in_valid_i`  in  1: request valid.
- `in_ready_o`  out  1: request accepted when high together with `in_valid_i`.
- `op_i`  in  3: funct3 encoding from the shared package (`INST_DIV`, `INST_DIVU`, `INST_REM`, `INST_REMU`).
- `dividend_i`  in  WIDTH: rs1.
- `divisor_i`  in  WIDTH: rs2.
- `tag_i`  in  TAG_W: tag captured at accept.
- `flush_i`  in  1: kill any in-flight operation.
- `out_valid_o`  out  1: result valid; held until consumed.
- `out_ready_i`  in  1: consumer accepts the result.
- `result_o`  out  WIDTH: quotient or remainder.
- `tag_o`  out  TAG_W: tag of the current result.

## Operation
- States: IDLE, CALC, FIX, OUT. Encoded as a package enum.
- **IDLE**
  - `in_ready_o = 1` only in IDLE and only when `rst_i` is low.
  - On accept, register the op, the tag, the absolute values of both operands, the quotient sign and the remainder sign. Signs are computed only for DIV/REM.
  - Special cases: on accept, the result is loaded directly and the state goes to OUT.
    - Divisor 0: DIV/DIVU → all ones; REM/REMU → dividend.
    - Signed overflow (dividend = most-negative, divisor = all ones, DIV/REM only): DIV → dividend; REM → 0.
    - `op_i[2] = 0` (not a divide op): result 0.
  - Otherwise clear the counter and the partial remainder, then go to CALC.
- **CALC**
  - Run N = `WIDTH`/`BITS_PER_CYCLE` cycles. Each cycle performs `BITS_PER_CYCLE` chained restoring steps: shift the next dividend bit into the remainder, compare against the divisor, subtract if greater or equal, shift the quotient bit in.
  - All intermediate values are unsigned and `WIDTH+1` bits wide.
  - Go to FIX after the Nth cycle.
- **FIX**
  - Negate the quotient if the quotient sign is set.
  - Negate the remainder if the dividend was negative (signed ops).
  - Select the quotient or remainder by op into `result_o`, then go to OUT.
- **OUT**
  - `out_valid_o = 1`. `result_o` and `tag_o` stay stable until `out_ready_i`.
  - On `out_ready_i`, go to IDLE. A new request cannot be accepted in the same cycle.
- **flush_i**
  - Highest priority after reset, in any state: next state IDLE and `out_valid_o` deasserts next cycle.
  - A request presented in the same cycle as `flush_i` is not accepted.

## Timing
- Reset values: `out_valid_o` 0, `result_o` 0, `tag_o` 0, state IDLE. `in_ready_o` is 0 while `rst_i` is high and 1 in the first cycle after.
- Reset mid-operation aborts it; no result is produced.
- Normal latency: `out_valid_o` rises N+2 cycles after the accept edge. This is 34 for `WIDTH`=32, `BITS_PER_CYCLE`=1, and 10 for `BITS_PER_CYCLE`=4.
- Special-case latency: `out_valid_o` rises 1 cycle after accept.
- Minimum initiation interval: latency + 1 cycle (the OUT handshake cycle returns to IDLE).
- Outputs are registered. `in_ready_o` is decoded from state only, with no combinational path from `in_valid_i`.

## Configuration
- `DIV_RESULT_CACHE_EN`
  - **Defined:** keep the last completed operands, their signedness, the final quotient and the final remainder. Cache update rules:
    - A non-special request matching dividend, divisor and signedness goes straight to OUT with the cached value; latency 1.
    - The cache is cleared on reset and on `flush_i`.
    - It is updated only when FIX completes.
  - **Undefined:** no cache registers exist; every request takes the full latency.

## Structure
- The shared package `tinyriscv_pkg` holds:
  - the `INST_DIV`/`INST_DIVU`/`INST_REM`/`INST_REMU` encodings;
  - the `div_state_e` enum;
  - the `DIV_MAX_BPC` constant (4).
- One sub-module, `div_step`: purely combinational. It takes the remainder, the dividend bits and the divisor, and returns the updated remainder and `BITS_PER_CYCLE` quotient bits. It is instantiated once, and the FSM wraps it.

## Test plan
- **Unsigned divide:** DIVU 100/7 and REMU 100/7 (`WIDTH`=32, `BITS_PER_CYCLE`=1) → 14 and 2; `out_valid_o` 34 cycles after accept; `tag_o` = `tag_i`.
- **Signed divide:** DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIV 7/−2 → 0xFFFFFFFD; REM 7/−2 → 1.
- **Divide by zero:** DIV 5/0 → 0xFFFFFFFF; REM 5/0 → 5; each valid 1 cycle after accept.
- **Overflow:** DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0; DIVU with the same operands → 0 at full latency.
- **Backpressure and flush:**
  - Hold `out_ready_i`=0 for 5 cycles → `result_o`/`tag_o` stable and `out_valid_o` held.
  - Assert `flush_i` at CALC cycle 10 → no `out_valid_o`, and `in_ready_o`=1 in the next cycle.
- **Wide configuration and cache:**
  - `WIDTH`=64, `BITS_PER_CYCLE`=4: DIVU 2^40/3 → 0x5555555555, latency 18.
  - With `DIV_RESULT_CACHE_EN`, DIV 100/7 followed by REM 100/7 → REM result 2 valid 1 cycle after accept.
